// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle CPU control FSM (IF/ID/EX/MEM/WB/HALT) with retired-instruction counter
//
// Purpose: sequences one instruction at a time through fetch, decode,
// execute, memory and write-back. Produces the datapath control word
// from the current state, opcode and funct. Counts retired instructions.
//
// Ports:
//   clk        in   1  rising-edge clock
//   reset_n    in   1  asynchronous active-low reset
//   opcode     in   4  instruction[15:12]
//   funct      in   6  instruction[5:0], used only when opcode == 15
//   mem_ready  in   1  memory access completes in the cycle it is 1
//   signal     out 15  {PCSource[1:0], ALUOp, ALUSrcB[1:0], ALUSrcA, RegWrite,
//                       RegDst, PCWriteCond, PCWrite, IorD, MemRead, MemWrite,
//                       MemtoReg, IRWrite}
//   num_inst   out 16  retired instruction count, wraps modulo 2^16
//   is_halted  out  1  1 once HLT has executed

module multicycle_control (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        mem_ready,
  output logic [14:0] signal,
  output logic [15:0] num_inst,
  output logic        is_halted
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [3:0] OP_ADI = 4'd4;
  localparam logic [3:0] OP_ORI = 4'd5;
  localparam logic [3:0] OP_LHI = 4'd6;
  localparam logic [3:0] OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8;
  localparam logic [3:0] OP_JMP = 4'd9;
  localparam logic [3:0] OP_JAL = 4'd10;
  localparam logic [3:0] OP_R   = 4'd15;

  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_num_inst;

  // Instruction class decode
  logic w_rtype, w_branch, w_r_alu, w_jpr, w_jrl, w_wwd, w_hlt;
  logic w_imm_signed, w_imm_zero, w_mem_op, w_to_ex;

  assign w_rtype      = (opcode == OP_R);
  assign w_branch     = (opcode[3:2] == 2'b00);
  assign w_r_alu      = w_rtype && (funct <= 6'd7);
  assign w_jpr        = w_rtype && (funct == FN_JPR);
  assign w_jrl        = w_rtype && (funct == FN_JRL);
  assign w_wwd        = w_rtype && (funct == FN_WWD);
  assign w_hlt        = w_rtype && (funct == FN_HLT);
  assign w_imm_signed = (opcode == OP_ADI) || (opcode == OP_LWD) || (opcode == OP_SWD);
  assign w_imm_zero   = (opcode == OP_ORI) || (opcode == OP_LHI);
  assign w_mem_op     = (opcode == OP_LWD) || (opcode == OP_SWD);
  // Anything not listed here falls back to IF from ID and behaves as a NOP
  assign w_to_ex      = w_branch || w_imm_signed || w_imm_zero || w_r_alu || w_wwd;

  // Control word fields
  logic [1:0] w_pc_source, w_alu_src_b;
  logic       w_alu_op, w_alu_src_a, w_reg_write, w_reg_dst, w_pc_write_cond;
  logic       w_pc_write, w_i_or_d, w_mem_read, w_mem_write, w_mem_to_reg, w_ir_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IF;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next          = r_state;
    w_pc_source     = 2'b00;
    w_alu_src_b     = 2'b00;
    w_alu_op        = 1'b0;
    w_alu_src_a     = 1'b0;
    w_reg_write     = 1'b0;
    w_reg_dst       = 1'b0;
    w_pc_write_cond = 1'b0;
    w_pc_write      = 1'b0;
    w_i_or_d        = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_ir_write      = 1'b0;

    case (r_state)
      S_IF: begin
        w_mem_read  = 1'b1;
        w_ir_write  = 1'b1;
        w_alu_src_b = 2'b01;
        // PC+1 is committed only in the cycle the fetch completes
        w_pc_write  = mem_ready;
        if (mem_ready) w_next = S_ID;
      end

      S_ID: begin
        w_alu_src_b = 2'b10;
        if ((opcode == OP_JMP) || (opcode == OP_JAL)) begin
          w_pc_write  = 1'b1;
          w_pc_source = 2'b10;
        end else if (w_jpr || w_jrl) begin
          w_pc_write  = 1'b1;
          w_alu_src_a = 1'b1;
        end

        if ((opcode == OP_JMP) || w_jpr)      w_next = S_IF;
        else if ((opcode == OP_JAL) || w_jrl) w_next = S_WB;
        else if (w_hlt)                       w_next = S_HALT;
        else if (w_to_ex)                     w_next = S_EX;
        else                                  w_next = S_IF;
      end

      S_EX: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 1'b1;
        if (w_imm_signed)    w_alu_src_b = 2'b10;
        else if (w_imm_zero) w_alu_src_b = 2'b11;
        else                 w_alu_src_b = 2'b00;

        if (w_branch) begin
          w_pc_write_cond = 1'b1;
          w_next          = S_IF;
        end else if (w_mem_op) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end

      S_MEM: begin
        w_i_or_d = 1'b1;
        if (opcode == OP_LWD) w_mem_read  = 1'b1;
        else                  w_mem_write = 1'b1;
        if (mem_ready) w_next = (opcode == OP_LWD) ? S_WB : S_IF;
      end

      S_WB: begin
        // WWD also asserts RegWrite; the datapath masks the actual write
        w_reg_write  = 1'b1;
        w_reg_dst    = w_rtype;
        w_mem_to_reg = (opcode == OP_LWD);
        w_next       = S_IF;
      end

      S_HALT: begin
        w_next = S_HALT;
      end

      default: begin
        w_next = S_IF;
      end
    endcase
  end

  // An instruction retires when control returns to IF from a later stage,
  // or when HLT enters HALT
  logic w_retire;
  assign w_retire = ((r_state != S_IF) && (r_state != S_HALT) && (w_next == S_IF)) ||
                    ((r_state != S_HALT) && (w_next == S_HALT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_num_inst <= 16'h0000;
    end else if (w_retire) begin
      r_num_inst <= r_num_inst + 16'h0001;
    end
  end

  logic [14:0] w_signal;
  assign w_signal = {w_pc_source, w_alu_op, w_alu_src_b, w_alu_src_a, w_reg_write,
                     w_reg_dst, w_pc_write_cond, w_pc_write, w_i_or_d, w_mem_read,
                     w_mem_write, w_mem_to_reg, w_ir_write};

  // The reset state is IF, whose fetch controls must not reach the datapath
  // while reset is held
  assign signal    = reset_n ? w_signal : 15'h0000;
  assign num_inst  = r_num_inst;
  assign is_halted = (r_state == S_HALT);

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, with ports named clk and reset_n.
REQ-002 Port clk SHALL be an input, 1 bit wide: the rising-edge clock.
REQ-003 Port reset_n SHALL be an input, 1 bit wide: asynchronous active-low reset.
REQ-004 Port opcode SHALL be an input, 4 bits wide: instruction[15:12] from the datapath.
REQ-005 Port funct SHALL be an input, 6 bits wide: instruction[5:0], meaningful only when opcode is 15.
REQ-006 Port mem_ready SHALL be an input, 1 bit wide: the memory access completes in the cycle it is 1.
REQ-007 Port signal SHALL be an output, 15 bits wide, with this bit layout:
- [14:13] PCSource
- [12] ALUOp
- [11:10] ALUSrcB
- [9] ALUSrcA
- [8] RegWrite
- [7] RegDst
- [6] PCWriteCond
- [5] PCWrite
- [4] IorD
- [3] MemRead
- [2] MemWrite
- [1] MemtoReg
- [0] IRWrite
REQ-008 Port num_inst SHALL be an output, 16 bits wide: count of retired instructions.
REQ-009 Port is_halted SHALL be an output, 1 bit wide: 1 once HLT has executed.

Function
REQ-010 The FSM SHALL have these states: IF, ID, EX, MEM, WB, HALT; state SHALL be registered and signal SHALL be a combinational decode of state, opcode and funct (Moore per state).
REQ-011 IF SHALL drive the following fields and hold in IF while mem_ready=0:
- MemRead=1, IorD=0, IRWrite=1.
- ALUSrcA=0, ALUSrcB=01, ALUOp=0.
- PCSource=00.
- PCWrite=1 only in the cycle mem_ready=1; all other fields 0.
REQ-012 IF SHALL go to ID on mem_ready=1.
REQ-013 ID SHALL drive ALUSrcA=0, ALUSrcB=10, ALUOp=0 (branch target).
REQ-014 ID SHALL additionally drive PCWrite=1 and PCSource=10 for JMP(9) and JAL(10); ID SHALL drive PCWrite=1 and PCSource=00 with ALUSrcA=1 for JPR(15/25) and JRL(15/26).
REQ-015 ID next state SHALL be:
- IF for JMP and JPR.
- WB for JAL and JRL.
- HALT for HLT (15/29).
- EX for all others.
REQ-016 EX SHALL drive ALUSrcA=1 and ALUOp=1, with ALUSrcB selected as follows:
- 00 for R-type and branches (0-3).
- 10 for ADI(4), LWD(7), SWD(8).
- 11 for ORI(5), LHI(6).
REQ-017 For branches, EX SHALL additionally drive PCWriteCond=1 and PCSource=00.
REQ-018 EX next state SHALL be:
- IF for branches.
- MEM for LWD and SWD.
- WB for all others, including WWD (15/28).
REQ-019 MEM SHALL drive IorD=1 with MemRead=1 (LWD) or MemWrite=1 (SWD), hold in MEM while mem_ready=0, and on mem_ready=1 go to WB for LWD or IF for SWD.
REQ-020 WB SHALL drive RegWrite=1, with RegDst=1 for R-type (opcode 15) and MemtoReg=1 for LWD; WB SHALL then go to IF.
REQ-021 Under WWD, RegWrite=1 in WB SHALL be driven, because the datapath latches its output on this edge and suppresses the register write itself.
REQ-022 An unknown opcode or funct SHALL be treated as a NOP: IF→ID→IF with no writes beyond the PC increment.
REQ-023 num_inst SHALL increment by 1, modulo 2^16 (FFFF wraps to 0000), on each transition into IF from ID, EX, MEM or WB, and on entry into HALT.
REQ-024 HALT SHALL be terminal: all signal bits 0, is_halted=1, num_inst frozen; only reset SHALL exit HALT.
REQ-025 MemRead and MemWrite SHALL never both be 1; PCWrite and PCWriteCond SHALL never both be 1.

Reset
REQ-026 reset_n=0 SHALL immediately, without waiting for clk, force state=IF, num_inst=0 and is_halted=0.
REQ-027 While reset_n=0, signal SHALL be all zeros.
REQ-028 Reset asserted mid-instruction (any state, including a MEM stall) SHALL abandon the instruction without counting it.
REQ-029 The first rising edge after reset_n returns to 1 SHALL evaluate IF.

Verification
REQ-030 Reset, then an ADD (opcode 15, funct 0) with mem_ready=1 → states IF, ID, EX, WB, IF over 4 cycles; WB signal=0x0180; num_inst=1.
REQ-031 LWD with mem_ready held 0 for 3 cycles in MEM → MEM lasts 4 cycles with IorD=1 and MemRead=1 throughout, then WB with MemtoReg=1; num_inst increments once.
REQ-032 BEQ (opcode 1) → exactly 3 cycles (IF, ID, EX); EX has PCWriteCond=1 and PCWrite=0.
REQ-033 JMP → 2 cycles; ID has PCWrite=1 and PCSource=10; the next state is IF.
REQ-034 HLT → is_halted=1 and signal=0 indefinitely; num_inst incremented once; then reset_n=0 mid-cycle → is_halted=0 and num_inst=0 asynchronously.
REQ-035 Preload num_inst=0xFFFF (force), then retire one instruction → num_inst=0x0000.
